// File: rtl/cdb_arbiter.sv
// rtl/cdb_arbiter.sv - round-robin Common Data Bus arbiter with registered broadcast
// Optional counters stat_bcast/stat_stall are built when CDB_STATS_EN is defined.
module cdb_arbiter #(
   parameter int NUM_REQ    = 4,
   parameter int TAG_WIDTH  = 4,
   parameter int DATA_WIDTH = 32,
   localparam int PW        = $clog2(NUM_REQ)
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic                          flush,
   input  logic [NUM_REQ-1:0]            req,
   input  logic [NUM_REQ*TAG_WIDTH-1:0]  req_tag,
   input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
   output logic [NUM_REQ-1:0]            grant,
   output logic                          cdb_valid,
   output logic [TAG_WIDTH-1:0]          cdb_tag,
   output logic [DATA_WIDTH-1:0]         cdb_data,
   output logic [PW-1:0]                 cdb_src
`ifdef CDB_STATS_EN
   ,
   output logic [31:0]                   stat_bcast,
   output logic [31:0]                   stat_stall
`endif
);

   logic [PW-1:0] ptr;
   logic [PW-1:0] win_idx;
   logic          found;

   // Scan from ptr upward with wrap; first requester wins.
   always_comb begin
      int idx;
      grant   = '0;
      win_idx = '0;
      found   = 1'b0;
      idx     = 0;
      if (!rst && !flush) begin
         for (int k = 0; k < NUM_REQ; k++) begin
            idx = (int'(ptr) + k) % NUM_REQ;
            if (!found && req[idx]) begin
               found      = 1'b1;
               grant[idx] = 1'b1;
               win_idx    = PW'(idx);
            end
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         cdb_valid <= 1'b0;
         cdb_tag   <= '0;
         cdb_data  <= '0;
         cdb_src   <= '0;
         ptr       <= '0;
      end else begin
         cdb_valid <= found;
         if (found) begin
            cdb_tag  <= req_tag[win_idx*TAG_WIDTH +: TAG_WIDTH];
            cdb_data <= req_data[win_idx*DATA_WIDTH +: DATA_WIDTH];
            cdb_src  <= win_idx;
            ptr      <= (win_idx == PW'(NUM_REQ-1)) ? '0 : win_idx + 1'b1;
         end
      end
   end

`ifdef CDB_STATS_EN
   // A stall cycle is counted once, however many units lose it.
   always_ff @(posedge clk) begin
      if (rst) begin
         stat_bcast <= '0;
         stat_stall <= '0;
      end else if (!flush) begin
         if (found)
            stat_bcast <= stat_bcast + 32'd1;
         if (((|req) && !found) || ($countones(req) > 1))
            stat_stall <= stat_stall + 32'd1;
      end
   end
`endif

endmodule

// File: tb/tb_cdb_arbiter.sv
// tb/tb_cdb_arbiter.sv - scoreboard bench for cdb_arbiter (NUM_REQ=4)
// Stats checks are compiled when CDB_STATS_EN is defined.
module tb_cdb_arbiter;

   localparam int N  = 4;
   localparam int TW = 4;
   localparam int DW = 32;

   logic            clk = 1'b0;
   logic            rst;
   logic            flush;
   logic [N-1:0]    req;
   logic [N*TW-1:0] req_tag;
   logic [N*DW-1:0] req_data;
   logic [N-1:0]    grant;
   logic            cdb_valid;
   logic [TW-1:0]   cdb_tag;
   logic [DW-1:0]   cdb_data;
   logic [1:0]      cdb_src;
`ifdef CDB_STATS_EN
   logic [31:0]     stat_bcast;
   logic [31:0]     stat_stall;
`endif

   cdb_arbiter #(.NUM_REQ(N), .TAG_WIDTH(TW), .DATA_WIDTH(DW)) dut (
      .clk       (clk),
      .rst       (rst),
      .flush     (flush),
      .req       (req),
      .req_tag   (req_tag),
      .req_data  (req_data),
      .grant     (grant),
      .cdb_valid (cdb_valid),
      .cdb_tag   (cdb_tag),
      .cdb_data  (cdb_data),
      .cdb_src   (cdb_src)
`ifdef CDB_STATS_EN
      ,
      .stat_bcast(stat_bcast),
      .stat_stall(stat_stall)
`endif
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [TW-1:0] tag;
      logic [DW-1:0] data;
      logic [1:0]    src;
   } bcast_t;

   bcast_t        sb[$];
   bcast_t        last;
   int            n_checks = 0;
   int            n_errors = 0;
   int            m_ptr    = 0;
   logic [31:0]   m_bcast  = 0;
   logic [31:0]   m_stall  = 0;

   task automatic check(input string name, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", name, obs, exp);
      end
   endtask

   // One clock cycle: check grant mid-cycle against the model, then the broadcast after the edge.
   task automatic step();
      logic [N-1:0] eg;
      int           ones;
      bcast_t       b, e;
      @(negedge clk);
      eg = '0;
      if (!rst && !flush) begin
         for (int k = 0; k < N; k++) begin
            int idx;
            idx = (m_ptr + k) % N;
            if (eg == '0 && req[idx]) begin
               eg[idx]  = 1'b1;
               b.tag    = req_tag[idx*TW +: TW];
               b.data   = req_data[idx*DW +: DW];
               b.src    = 2'(idx);
               sb.push_back(b);
               m_ptr    = (idx + 1) % N;
            end
         end
      end
      check("grant", 64'(grant), 64'(eg));
      ones = $countones(req);
      if (rst) begin
         m_ptr   = 0;
         m_bcast = 0;
         m_stall = 0;
      end else if (!flush) begin
         if (eg != '0) m_bcast = m_bcast + 1;
         if ((req != '0 && eg == '0) || ones > 1) m_stall = m_stall + 1;
      end
      @(posedge clk);
      #1;
      if (rst) begin
         last = '{tag: '0, data: '0, src: '0};
         sb.delete();
      end
      if (sb.size() > 0) begin
         e = sb.pop_front();
         check("cdb_valid", 64'(cdb_valid), 64'(1));
         last = e;
      end else begin
         check("cdb_valid", 64'(cdb_valid), 64'(0));
      end
      check("cdb_tag", 64'(cdb_tag), 64'(last.tag));
      check("cdb_data", 64'(cdb_data), 64'(last.data));
      check("cdb_src", 64'(cdb_src), 64'(last.src));
   endtask

   task automatic rand_payload();
      for (int i = 0; i < N; i++) begin
         req_tag[i*TW +: TW]  = 4'($urandom);
         req_data[i*DW +: DW] = $urandom;
      end
   endtask

   task automatic do_reset();
      rst = 1'b1;
      step();
      rst = 1'b0;
   endtask

   initial begin
      last     = '{tag: '0, data: '0, src: '0};
      rst      = 1'b1;
      flush    = 1'b0;
      req      = '0;
      req_tag  = '0;
      req_data = '0;
      @(posedge clk);
      #1;
      step();
      rst = 1'b0;
      check("rst_valid", 64'(cdb_valid), 64'(0));
      check("rst_tag", 64'(cdb_tag), 64'(0));
      check("rst_data", 64'(cdb_data), 64'(0));

      // single requester, tag 3 data 30
      req = 4'b0001;
      req_tag[0 +: TW]  = 4'd3;
      req_data[0 +: DW] = 32'd30;
      step();
      check("t1_tag", 64'(cdb_tag), 64'(3));
      check("t1_data", 64'(cdb_data), 64'(30));
      req = '0;
      step();

      // all requesting: rotation 0,1,2,3,0
      do_reset();
      rand_payload();
      req = 4'b1111;
      for (int i = 0; i < 5; i++) begin
         step();
         check("t2_src", 64'(cdb_src), 64'(i % N));
      end

      // pointer past 0 -> unit3 before unit0
      do_reset();
      req = 4'b0001;
      step();
      req = 4'b1001;
      step();
      check("t3_src3", 64'(cdb_src), 64'(3));
      req = 4'b0001;
      step();
      check("t3_src0", 64'(cdb_src), 64'(0));

      // flush holds ptr; unit1 wins afterwards
      req   = 4'b0110;
      flush = 1'b1;
      step();
      flush = 1'b0;
      step();
      check("t4_src1", 64'(cdb_src), 64'(1));

      // reset right after a grant
      req = 4'b0001;
      step();
      rst = 1'b1;
      req = 4'b1010;
      step();
      rst = 1'b0;
      step();
      check("t5_src1", 64'(cdb_src), 64'(1));

      // ten cycles with two requesters
      do_reset();
      req = 4'b0011;
      for (int i = 0; i < 10; i++) step();
`ifdef CDB_STATS_EN
      check("stat_bcast", 64'(stat_bcast), 64'(10));
      check("stat_stall", 64'(stat_stall), 64'(10));
`endif

      // random traffic with occasional flush
      for (int i = 0; i < 300; i++) begin
         rand_payload();
         req   = 4'($urandom);
         flush = ($urandom_range(0, 9) == 0);
         step();
      end
      flush = 1'b0;
      req   = '0;
      step();
`ifdef CDB_STATS_EN
      check("stat_bcast_rand", 64'(stat_bcast), 64'(m_bcast));
      check("stat_stall_rand", 64'(stat_stall), 64'(m_stall));
`endif

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
